// File: rtl/count_monitor_pkg.sv
// Shared state encoding for the count-stream sequence monitor.
package count_monitor_pkg;

  localparam int unsigned StateW = 2;

  localparam logic [StateW-1:0] ST_IDLE   = 2'b00;
  localparam logic [StateW-1:0] ST_SYNC   = 2'b01;
  localparam logic [StateW-1:0] ST_LOCKED = 2'b10;

  typedef enum logic [StateW-1:0] {
    StIdle   = ST_IDLE,
    StSync   = ST_SYNC,
    StLocked = ST_LOCKED,
    StBad    = 2'b11
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/count_monitor.sv
// Locks onto a +1 count stream and reports skips, early restarts and wraps.
// Define COUNT_MONITOR_STICKY_ERR_EN to make err hold until clr or rst.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned LOCK_N = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              count_vld,
  input  logic              clr,
  output logic              locked,
  output logic              err,
  output logic              restart,
  output logic              wrap,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  wrap_cnt,
  output logic [StateW-1:0] state
);

  localparam int unsigned MatchW = $clog2(LOCK_N + 1);
  localparam logic [MatchW-1:0] LockN = MatchW'(LOCK_N);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic [MatchW-1:0]  match_q, match_d, match_inc;
  logic [CNT_W-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic               err_q, err_d;
  logic               restart_q, restart_d;
  logic               wrap_q, wrap_d;
  logic               err_evt;
  logic               err_clr;
  logic [WIDTH-1:0]   count_inc;

  assign match_inc = match_q + MatchW'(1);
  assign count_inc = count_in + WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    match_d    = match_q;
    wrap_cnt_d = wrap_cnt_q;
    restart_d  = 1'b0;
    wrap_d     = 1'b0;
    err_evt    = 1'b0;
    err_clr    = 1'b0;

    // clr wins over any sample presented in the same cycle
    if (clr) begin
      state_d    = StIdle;
      exp_d      = '0;
      match_d    = '0;
      wrap_cnt_d = '0;
      err_clr    = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (count_vld) begin
            state_d = StSync;
            exp_d   = count_inc;
            match_d = '0;
          end
        end
        StSync: begin
          if (count_vld) begin
            if (count_in == exp_q) begin
              exp_d = count_inc;
              if (match_inc == LockN) begin
                state_d = StLocked;
                match_d = '0;
              end else begin
                match_d = match_inc;
              end
            end else begin
              match_d = '0;
              exp_d   = count_inc;
            end
          end
        end
        StLocked: begin
          if (count_vld) begin
            if (count_in == exp_q) begin
              exp_d = count_inc;
              if (count_in == '0) begin
                wrap_d     = 1'b1;
                wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
              end
            end else if (count_in == '0) begin
              // observed counter was reset: resync without counting an error
              restart_d = 1'b1;
              state_d   = StSync;
              match_d   = '0;
              exp_d     = WIDTH'(1);
            end else begin
              err_evt = 1'b1;
              state_d = StSync;
              match_d = '0;
              exp_d   = count_inc;
            end
          end
        end
        default: begin
          state_d = StIdle;
          exp_d   = '0;
          match_d = '0;
        end
      endcase
    end

`ifdef COUNT_MONITOR_STICKY_ERR_EN
    err_d = ~err_clr & (err_q | err_evt);
`else
    err_d = err_evt;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      exp_q      <= '0;
      match_q    <= '0;
      wrap_cnt_q <= '0;
      err_q      <= 1'b0;
      restart_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      match_q    <= match_d;
      wrap_cnt_q <= wrap_cnt_d;
      err_q      <= err_d;
      restart_q  <= restart_d;
      wrap_q     <= wrap_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_evt),
    .clr (err_clr),
    .cnt (err_cnt)
  );

  assign locked   = (state_q == StLocked);
  assign err      = err_q;
  assign restart  = restart_q;
  assign wrap     = wrap_q;
  assign wrap_cnt = wrap_cnt_q;
  assign state    = state_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed self-checking bench for count_monitor (WIDTH=4, LOCK_N=3, CNT_W=8).
module tb_count_monitor;

`ifdef COUNT_MONITOR_STICKY_ERR_EN
  localparam bit Sticky = 1'b1;
`else
  localparam bit Sticky = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count_in;
  logic       count_vld;
  logic       clr;
  logic       locked, err, restart, wrap;
  logic [7:0] err_cnt, wrap_cnt;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  count_monitor #(
    .WIDTH  (4),
    .LOCK_N (3),
    .CNT_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .count_vld (count_vld),
    .clr       (clr),
    .locked    (locked),
    .err       (err),
    .restart   (restart),
    .wrap      (wrap),
    .err_cnt   (err_cnt),
    .wrap_cnt  (wrap_cnt),
    .state     (state)
  );

  // Present one sample, then sample the registered response 1 ns after the edge.
  task automatic step(input logic v, input logic [3:0] d);
    @(negedge clk);
    count_vld = v;
    count_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; count_vld = 1'b0; count_in = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", state); end
    n_checks++; if ({locked, err, restart, wrap} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {locked, err, restart, wrap}); end
    n_checks++; if ({err_cnt, wrap_cnt} !== 16'h0) begin n_fail++; $display("FAIL reset_cnts: got %h want 0000", {err_cnt, wrap_cnt}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lock();
    step(1'b1, 4'd0);
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL lock_sync0: state %b want 01", state); end
    step(1'b1, 4'd1);
    step(1'b1, 4'd2);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: locked %b want 0", locked); end
    step(1'b1, 4'd3);
    n_checks++; if (locked !== 1'b1 || state !== 2'b10) begin n_fail++; $display("FAIL lock_at3: locked %b state %b want 1 10", locked, state); end
    step(1'b1, 4'd4);
    n_checks++; if (locked !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL lock_hold: locked %b err %b want 1 0", locked, err); end
  endtask

  task automatic test_wrap();
    for (int v = 5; v <= 15; v++) step(1'b1, 4'(v));
    n_checks++; if (wrap !== 1'b0 || wrap_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_pre: wrap %b cnt %0d want 0 0", wrap, wrap_cnt); end
    step(1'b1, 4'd0);
    n_checks++; if (wrap !== 1'b1 || wrap_cnt !== 8'd1 || locked !== 1'b1) begin n_fail++; $display("FAIL wrap_pulse: wrap %b cnt %0d locked %b want 1 1 1", wrap, wrap_cnt, locked); end
    step(1'b1, 4'd1);
    n_checks++; if (wrap !== 1'b0 || wrap_cnt !== 8'd1) begin n_fail++; $display("FAIL wrap_after: wrap %b cnt %0d want 0 1", wrap, wrap_cnt); end
  endtask

  task automatic test_error();
    for (int v = 2; v <= 6; v++) step(1'b1, 4'(v));
    step(1'b1, 4'd9);
    n_checks++; if (err !== 1'b1 || err_cnt !== 8'd1 || state !== 2'b01) begin n_fail++; $display("FAIL err_skip: err %b cnt %0d state %b want 1 1 01", err, err_cnt, state); end
    step(1'b1, 4'd10);
    n_checks++; if (err !== Sticky || state !== 2'b01) begin n_fail++; $display("FAIL err_next: err %b state %b want %b 01", err, state, Sticky); end
    step(1'b1, 4'd11);
    step(1'b1, 4'd12);
    n_checks++; if (locked !== 1'b1 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL err_relock: locked %b cnt %0d want 1 1", locked, err_cnt); end
  endtask

  task automatic test_restart();
    step(1'b1, 4'd13); step(1'b1, 4'd14); step(1'b1, 4'd15); step(1'b1, 4'd0);
    n_checks++; if (wrap_cnt !== 8'd2) begin n_fail++; $display("FAIL rst_wrap2: wrap_cnt %0d want 2", wrap_cnt); end
    for (int v = 1; v <= 7; v++) step(1'b1, 4'(v));
    step(1'b1, 4'd0);
    n_checks++; if (restart !== 1'b1 || err !== Sticky || err_cnt !== 8'd1 || state !== 2'b01 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL restart_pulse: restart %b err %b cnt %0d state %b wrap %b want 1 %b 1 01 0", restart, err, err_cnt, state, wrap, Sticky); end
    step(1'b1, 4'd1);
    n_checks++; if (restart !== 1'b0) begin n_fail++; $display("FAIL restart_clear: restart %b want 0", restart); end
    step(1'b1, 4'd2); step(1'b1, 4'd3);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL restart_relock: locked %b want 1", locked); end
    step(1'b0, 4'd9);
    n_checks++; if (locked !== 1'b1 || err !== Sticky || err_cnt !== 8'd1) begin n_fail++; $display("FAIL vld_low: locked %b err %b cnt %0d want 1 %b 1", locked, err, err_cnt, Sticky); end
    step(1'b1, 4'd4);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL vld_resume: locked %b want 1", locked); end
  endtask

  task automatic test_saturate_clr();
    logic [3:0] nxt, bad;
    nxt = 4'd5;
    for (int i = 0; i < 260; i++) begin
      step(1'b1, nxt); step(1'b1, nxt + 4'd1); step(1'b1, nxt + 4'd2);
      bad = nxt + 4'd5;
      if (bad == 4'd0) bad = 4'd1;
      step(1'b1, bad);
      if (i == 0) begin
        n_checks++; if (err !== 1'b1 || err_cnt !== 8'd2) begin n_fail++; $display("FAIL sat_first: err %b cnt %0d want 1 2", err, err_cnt); end
      end
      if (i == 252) begin
        n_checks++; if (err_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254: cnt %0d want 254", err_cnt); end
      end
      nxt = bad + 4'd1;
    end
    n_checks++; if (err_cnt !== 8'd255 || err !== 1'b1) begin n_fail++; $display("FAIL sat_full: cnt %0d err %b want 255 1", err_cnt, err); end
    clr = 1'b1;
    step(1'b1, nxt);
    clr = 1'b0;
    n_checks++; if (state !== 2'b00 || err_cnt !== 8'd0 || wrap_cnt !== 8'd0 || {locked, err, restart, wrap} !== 4'b0) begin
      n_fail++; $display("FAIL clr: state %b ecnt %0d wcnt %0d flags %b want 00 0 0 0000", state, err_cnt, wrap_cnt, {locked, err, restart, wrap}); end
  endtask

  task automatic test_async_reset();
    step(1'b1, 4'd13);
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL ar_sync: state %b want 01", state); end
    step(1'b1, 4'd14); step(1'b1, 4'd15); step(1'b1, 4'd0);
    n_checks++; if (locked !== 1'b1 || wrap !== 1'b0) begin n_fail++; $display("FAIL ar_lock: locked %b wrap %b want 1 0", locked, wrap); end
    step(1'b1, 4'd5);
    n_checks++; if (err !== 1'b1 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL ar_err: err %b cnt %0d want 1 1", err, err_cnt); end
    step(1'b1, 4'd6); step(1'b1, 4'd7); step(1'b1, 4'd8);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL ar_relock: locked %b want 1", locked); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (state !== 2'b00 || err_cnt !== 8'd0 || {locked, err, restart, wrap} !== 4'b0) begin
      n_fail++; $display("FAIL ar_immediate: state %b cnt %0d flags %b want 00 0 0000", state, err_cnt, {locked, err, restart, wrap}); end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 4'd3);
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL ar_resume: state %b want 01", state); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_error();
    test_restart();
    test_saturate_clr();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
